// File: rtl/ram_burst_writer_pkg.sv
// rtl/ram_burst_writer_pkg.sv - shared state type and source-slice helpers for the burst writer
package ram_burst_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  // LSB of source idx inside the packed source bus
  function automatic int src_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic logic sel_valid(input int sel, input int num_src);
    return sel < num_src;
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - 1-bit rising-edge detector with async active-high reset
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/ram_burst_writer.sv
// rtl/ram_burst_writer.sv - burst-framed RAM write controller with source select and wrapping address
module ram_burst_writer
  import ram_burst_writer_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int NUM_SRC   = 2,
  parameter int DEPTH     = 16,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int SEL_W    = $clog2(NUM_SRC),
  localparam int LEN_W    = ADDR_W + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [ADDR_W-1:0]            i_base_addr,
  input  logic [LEN_W-1:0]             i_len,
  input  logic                         i_wr_req,
  input  logic [SEL_W-1:0]             i_sel,
  input  logic [NUM_SRC*SIZE_DATA-1:0] i_data_src,
  output logic                         o_wr_en,
  output logic [ADDR_W-1:0]            o_addr,
  output logic [SIZE_DATA-1:0]         o_data_ram,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic              req_edge;

  rising_edge_detect u_req_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_wr_req),
    .rise (req_edge)
  );

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      addr       <= '0;
      rem        <= '0;
      o_wr_en    <= 1'b0;
      o_addr     <= '0;
      o_data_ram <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_wr_en    <= 1'b0;
      o_addr     <= '0;
      o_data_ram <= '0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr  <= i_base_addr;
            rem   <= i_len;
            o_err <= 1'b0;
            state <= (i_len != '0) ? ARMED : DONE;
          end
        end
        ARMED: begin
          // Abort takes priority over a coincident request edge.
          if (i_abort) begin
            state <= IDLE;
          end else if (req_edge) begin
            if (sel_valid(int'(i_sel), NUM_SRC)) begin
              o_wr_en    <= 1'b1;
              o_addr     <= addr;
              o_data_ram <= i_data_src[src_lsb(int'(i_sel), SIZE_DATA) +: SIZE_DATA];
              addr       <= addr + ADDR_W'(1);
              rem        <= rem - LEN_W'(1);
              if (rem == LEN_W'(1)) begin
                state <= DONE;
              end
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        DONE: begin
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_writer.sv
// tb/tb_ram_burst_writer.sv - randomized self-checking bench against a burst-level reference model
module tb_ram_burst_writer;

  localparam int SIZE_DATA = 8;
  localparam int NUM_SRC   = 3;   // three sources so that sel=3 is expressible and invalid
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int SEL_W     = 2;
  localparam int LEN_W     = 5;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         start = 1'b0;
  logic                         abort = 1'b0;
  logic [ADDR_W-1:0]            base_addr = '0;
  logic [LEN_W-1:0]             len = '0;
  logic                         wr_req = 1'b0;
  logic [SEL_W-1:0]             sel = '0;
  logic [SIZE_DATA-1:0]         src [NUM_SRC];
  logic [NUM_SRC*SIZE_DATA-1:0] data_src;
  logic                         wr_en;
  logic [ADDR_W-1:0]            addr;
  logic [SIZE_DATA-1:0]         data_ram;
  logic                         busy;
  logic                         done;
  logic                         err;

  assign data_src = {src[2], src[1], src[0]};

  always #5 clk = ~clk;

  ram_burst_writer #(
    .SIZE_DATA (SIZE_DATA),
    .NUM_SRC   (NUM_SRC),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_base_addr (base_addr),
    .i_len       (len),
    .i_wr_req    (wr_req),
    .i_sel       (sel),
    .i_data_src  (data_src),
    .o_wr_en     (wr_en),
    .o_addr      (addr),
    .o_data_ram  (data_ram),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Burst-level reference: a burst is (base, len); the k-th accepted write goes to (base+k) mod DEPTH.
  bit m_in_burst, m_finishing, m_req_prev, m_err;
  int m_base, m_len, m_count;
  bit e_wr, e_done;
  int e_addr, e_data;

  task automatic model_reset();
    m_in_burst = 0; m_finishing = 0; m_req_prev = 0; m_err = 0;
    m_base = 0; m_len = 0; m_count = 0;
    e_wr = 0; e_done = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step();
    bit rising;
    rising = wr_req && !m_req_prev;
    m_req_prev = wr_req;
    e_wr = 0; e_done = 0; e_addr = 0; e_data = 0;
    if (m_finishing) begin
      e_done = 1;
      m_finishing = 0;
    end else if (!m_in_burst) begin
      if (start) begin
        m_base = int'(base_addr); m_len = int'(len); m_count = 0; m_err = 0;
        if (m_len == 0) m_finishing = 1;
        else m_in_burst = 1;
      end
    end else if (abort) begin
      m_in_burst = 0;
    end else if (rising) begin
      if (int'(sel) < NUM_SRC) begin
        e_wr = 1;
        e_addr = (m_base + m_count) % DEPTH;
        e_data = int'(src[int'(sel)]);
        m_count++;
        if (m_count == m_len) begin
          m_in_burst = 0;
          m_finishing = 1;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare_outputs(input bit exp_busy);
    check_eq("wr_en", 32'(wr_en), 32'(e_wr));
    check_eq("addr", 32'(addr), 32'(e_addr));
    check_eq("data_ram", 32'(data_ram), 32'(e_data));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs(m_in_burst || m_finishing);
  endtask

  task automatic drive(input bit s, input bit a, input bit r, input int sl);
    start = s; abort = a; wr_req = r; sel = SEL_W'(sl);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_outputs(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic begin_burst(input int b, input int l);
    base_addr = ADDR_W'(b); len = LEN_W'(l);
    drive(1, 0, 0, 0);
  endtask

  task automatic pulse_req(input int sl);
    drive(0, 0, 1, sl);
    drive(0, 0, 0, sl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    src[0] = 8'hA5; src[1] = 8'h3C; src[2] = 8'h5A;
    model_reset();
    #3;
    do_reset();
    idle(2);

    // reset in the middle of a burst, then a fresh burst
    begin_burst(3, 4);
    pulse_req(0);
    do_reset();
    idle(2);

    // basic burst: addresses 2,3,4 with A5,3C,A5
    begin_burst(2, 3);
    pulse_req(0);
    pulse_req(1);
    pulse_req(0);
    idle(3);

    // level hold produces one write, then abort cleans up
    begin_burst(0, 2);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 1);
    drive(0, 1, 0, 0);
    idle(2);

    // address wrap 14,15,0,1
    begin_burst(14, 4);
    for (int i = 0; i < 4; i++) pulse_req(i % 3);
    idle(3);

    // zero length
    begin_burst(7, 0);
    idle(3);

    // bad select, then two valid writes; err sticky until next start
    begin_burst(5, 2);
    pulse_req(3);
    pulse_req(2);
    pulse_req(1);
    idle(4);
    begin_burst(1, 1);
    pulse_req(0);
    idle(2);

    // abort coinciding with a request edge
    begin_burst(9, 2);
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    pulse_req(0);
    idle(2);

    // start during ARMED must not disturb base/len
    begin_burst(5, 2);
    base_addr = 4'd9; len = 5'd7;
    drive(1, 0, 0, 0);
    pulse_req(0);
    pulse_req(1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset();
      end else begin
        for (int k = 0; k < NUM_SRC; k++) src[k] = SIZE_DATA'($urandom);
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        len = LEN_W'($urandom_range(0, 20));
        drive(($urandom % 8) == 0,
              ($urandom % 40) == 0,
              (($urandom % 3) == 0) ? !wr_req : wr_req,
              int'($urandom % 4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
